// File: rtl/instr_decode_stage.sv
// Decode pipeline stage with a two-entry skid buffer.
// Fetch hands over 32-bit instructions on a valid/ready handshake. Each instruction
// is decoded combinationally on the way in, and the decoded bundle is stored in a
// main or a skid register. All outputs are taken from the main register, and
// if_ready is itself a register, so execute stalls never reach fetch combinationally.
module instr_decode_stage #(
  parameter int DataSize = 32,
  parameter int AddrSize = 5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                if_valid,
  output logic                if_ready,
  input  logic [DataSize-1:0] if_instr,
  output logic                id_valid,
  input  logic                id_ready,
  output logic [4:0]          imm_5bit,
  output logic [14:0]         imm_15bit,
  output logic [19:0]         imm_20bit,
  output logic [1:0]          mux4to1_select,
  output logic [AddrSize-1:0] rt_addr,
  output logic [AddrSize-1:0] ra_addr,
  output logic [AddrSize-1:0] rb_addr,
  output logic                use_imm,
  output logic [4:0]          alu_op,
  output logic                illegal
);

  typedef struct packed {
    logic [4:0]          imm5;
    logic [14:0]         imm15;
    logic [19:0]         imm20;
    logic [1:0]          sel;
    logic [AddrSize-1:0] rt;
    logic [AddrSize-1:0] ra;
    logic [AddrSize-1:0] rb;
    logic                use_imm;
    logic [4:0]          alu_op;
    logic                illegal;
  } bundle_t;

  // The enum value is the number of buffered instructions.
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t  state, state_next;
  bundle_t dec, main_q, skid_q;
  logic    accept, consume;
  logic    load_main, load_skid, skid_to_main;
  logic [5:0] opcode;

  assign opcode  = if_instr[30:25];
  assign id_valid = (state != EMPTY);
  assign accept  = if_valid && if_ready;
  assign consume = id_valid && id_ready;

  // Decode the incoming fetch word into a bundle. Field slices pass through even for illegal opcodes.
  always_comb begin
    dec         = '0;
    dec.imm5    = if_instr[14:10];
    dec.imm15   = if_instr[14:0];
    dec.imm20   = if_instr[19:0];
    dec.rt      = if_instr[24:20];
    dec.ra      = if_instr[19:15];
    dec.rb      = if_instr[14:10];
    dec.illegal = 1'b0;
    if (if_instr[31]) begin
      dec.illegal = 1'b1;
    end else begin
      case (opcode)
        6'b100000: begin
          dec.alu_op  = if_instr[4:0];
          dec.use_imm = (if_instr[4:0] == 5'b01000) || (if_instr[4:0] == 5'b01001) ||
                        (if_instr[4:0] == 5'b01011);
        end
        6'b101000: begin dec.sel = 2'b01; dec.use_imm = 1'b1; dec.alu_op = 5'b00000; end
        6'b101100: begin dec.sel = 2'b10; dec.use_imm = 1'b1; dec.alu_op = 5'b00100; end
        6'b101011: begin dec.sel = 2'b10; dec.use_imm = 1'b1; dec.alu_op = 5'b00011; end
        6'b100010: begin dec.sel = 2'b11; dec.use_imm = 1'b1; dec.alu_op = 5'b11111; end
        default:   dec.illegal = 1'b1;
      endcase
    end
  end

  // Work out the next occupancy and which buffer register to load. Flush overrides everything.
  always_comb begin
    state_next   = state;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    skid_to_main = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state)
        EMPTY: if (accept) begin state_next = ONE; load_main = 1'b1; end
        ONE: begin
          if (accept && consume)  load_main = 1'b1;
          else if (accept)        begin state_next = TWO; load_skid = 1'b1; end
          else if (consume)       state_next = EMPTY;
        end
        TWO: if (consume) begin state_next = ONE; skid_to_main = 1'b1; end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Occupancy register, and a registered ready that is low only when both entries are full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= EMPTY;
      if_ready <= 1'b1;
    end else begin
      state    <= state_next;
      if_ready <= (state_next != TWO);
    end
  end

  // Main and skid bundle registers. Main is the only one visible on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)         main_q <= dec;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid)         skid_q <= dec;
    end
  end

  assign imm_5bit       = main_q.imm5;
  assign imm_15bit      = main_q.imm15;
  assign imm_20bit      = main_q.imm20;
  assign mux4to1_select = main_q.sel;
  assign rt_addr        = main_q.rt;
  assign ra_addr        = main_q.ra;
  assign rb_addr        = main_q.rb;
  assign use_imm        = main_q.use_imm;
  assign alu_op         = main_q.alu_op;
  assign illegal        = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Testbench for instr_decode_stage. The reference model is a FIFO of expected
// decoded bundles: it accepts while it holds fewer than two, shows its head on
// the outputs, and is emptied by flush or reset.
module tb_instr_decode_stage;

  typedef struct {
    logic [4:0]  imm5;
    logic [14:0] imm15;
    logic [19:0] imm20;
    logic [1:0]  sel;
    logic [4:0]  rt, ra, rb;
    logic        use_imm;
    logic [4:0]  alu_op;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] if_instr = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [4:0]  imm_5bit;
  logic [14:0] imm_15bit;
  logic [19:0] imm_20bit;
  logic [1:0]  mux4to1_select;
  logic [4:0]  rt_addr, ra_addr, rb_addr;
  logic        use_imm;
  logic [4:0]  alu_op;
  logic        illegal;

  int errors = 0;
  int checks = 0;
  exp_t model_q[$];

  instr_decode_stage #(.DataSize(32), .AddrSize(5)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .id_valid(id_valid), .id_ready(id_ready),
    .imm_5bit(imm_5bit), .imm_15bit(imm_15bit), .imm_20bit(imm_20bit),
    .mux4to1_select(mux4to1_select), .rt_addr(rt_addr), .ra_addr(ra_addr),
    .rb_addr(rb_addr), .use_imm(use_imm), .alu_op(alu_op), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Expected decode, looked up in a table of the immediate-form opcodes.
  function automatic exp_t refDecode(input logic [31:0] ins);
    logic [5:0] ops  [4] = '{6'b101000, 6'b101100, 6'b101011, 6'b100010};
    logic [1:0] sels [4] = '{2'b01, 2'b10, 2'b10, 2'b11};
    logic [4:0] alus [4] = '{5'd0, 5'd4, 5'd3, 5'd31};
    logic [5:0] op;
    logic [4:0] sub;
    exp_t e;
    op = ins[30:25];
    sub = ins[4:0];
    e.imm5 = ins[14:10]; e.imm15 = ins[14:0]; e.imm20 = ins[19:0];
    e.rt = ins[24:20]; e.ra = ins[19:15]; e.rb = ins[14:10];
    e.sel = 2'b00; e.use_imm = 1'b0; e.alu_op = 5'd0; e.illegal = 1'b1;
    if (ins[31] == 1'b0) begin
      if (op == 6'b100000) begin
        e.illegal = 1'b0;
        e.alu_op = sub;
        e.use_imm = (sub == 5'd8 || sub == 5'd9 || sub == 5'd11);
      end
      for (int i = 0; i < 4; i++)
        if (op == ops[i]) begin
          e.illegal = 1'b0; e.sel = sels[i]; e.use_imm = 1'b1; e.alu_op = alus[i];
        end
    end
    return e;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [4:0] ra, input logic [14:0] low);
    return {1'b0, op, rt, ra, low};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] check %s wrong", tag);
    end
  endtask

  // Compare every output with the model's head entry, or with the empty-buffer handshake state.
  task automatic checkOutput();
    chk("id_valid", 32'(id_valid), 32'(model_q.size() > 0));
    chk("if_ready", 32'(if_ready), 32'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      chk("imm_5bit",  32'(imm_5bit),       32'(model_q[0].imm5));
      chk("imm_15bit", 32'(imm_15bit),      32'(model_q[0].imm15));
      chk("imm_20bit", 32'(imm_20bit),      32'(model_q[0].imm20));
      chk("sel",       32'(mux4to1_select), 32'(model_q[0].sel));
      chk("rt_addr",   32'(rt_addr),        32'(model_q[0].rt));
      chk("ra_addr",   32'(ra_addr),        32'(model_q[0].ra));
      chk("rb_addr",   32'(rb_addr),        32'(model_q[0].rb));
      chk("use_imm",   32'(use_imm),        32'(model_q[0].use_imm));
      chk("alu_op",    32'(alu_op),         32'(model_q[0].alu_op));
      chk("illegal",   32'(illegal),        32'(model_q[0].illegal));
    end
  endtask

  task automatic checkZero(input string tag);
    chk({tag, "_valid"}, 32'(id_valid), 32'd0);
    chk({tag, "_ready"}, 32'(if_ready), 32'd1);
    chk({tag, "_data"}, 32'({imm_5bit, imm_15bit, imm_20bit, mux4to1_select}), 32'd0);
    chk({tag, "_regs"}, 32'({rt_addr, ra_addr, rb_addr, use_imm, alu_op, illegal}), 32'd0);
  endtask

  // Drive one cycle from a falling edge, update the model at the rising edge, then check.
  task automatic applyStimulus(input logic v, input logic [31:0] ins,
                               input logic rdy, input logic fl);
    bit acc, con;
    if_valid = v; if_instr = ins; id_ready = rdy; flush = fl;
    @(posedge clk);
    acc = v && (model_q.size() < 2);
    con = rdy && (model_q.size() > 0);
    if (fl) model_q.delete();
    else begin
      if (con) void'(model_q.pop_front());
      if (acc) model_q.push_back(refDecode(ins));
    end
    @(negedge clk);
    checkOutput();
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: begin r[31:25] = 7'b0100000; r[4:0] = ($urandom_range(0, 1) != 0) ? 5'd8 : 5'd11; end
      1: r[31:25] = 7'b0100000;
      2: r[31:25] = 7'b0101000;
      3: r[31:25] = 7'b0101100;
      4: r[31:25] = 7'b0101011;
      5: r[31:25] = 7'b0100010;
      6: r[31] = 1'b0;
      default: r[31] = 1'b1;
    endcase
    return r;
  endfunction

  initial begin
    logic [31:0] i1, i2, i3;
    // Reset state while reset is held.
    repeat (2) @(negedge clk);
    checkZero("reset");
    rst = 1'b1;
    checkOutput();

    // ADDI r1,r2,-1
    applyStimulus(1'b1, mk(6'b101000, 5'd1, 5'd2, 15'h7fff), 1'b1, 1'b0);
    chk("addi_sel", 32'(mux4to1_select), 32'd1);
    chk("addi_imm15", 32'(imm_15bit), 32'h7fff);
    chk("addi_rt_ra", 32'({rt_addr, ra_addr}), 32'({5'd1, 5'd2}));
    chk("addi_use_imm", 32'(use_imm), 32'd1);

    // MOVI r3,0x80000 then ORI r4,r5,0x4000 back to back.
    applyStimulus(1'b1, {1'b0, 6'b100010, 5'd3, 20'h80000}, 1'b1, 1'b0);
    chk("movi_sel", 32'(mux4to1_select), 32'd3);
    chk("movi_imm20", 32'(imm_20bit), 32'h80000);
    applyStimulus(1'b1, mk(6'b101100, 5'd4, 5'd5, 15'h4000), 1'b1, 1'b0);
    chk("ori_sel", 32'(mux4to1_select), 32'd2);
    chk("ori_imm15", 32'(imm_15bit), 32'h4000);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Three offered while stalled: two accepted, then drained in order.
    i1 = mk(6'b101011, 5'd6, 5'd7, 15'h0123);
    i2 = {1'b0, 6'b100000, 5'd8, 5'd9, 10'h155, 5'b01001};
    i3 = mk(6'b101000, 5'd10, 5'd11, 15'h5aa5);
    applyStimulus(1'b1, i1, 1'b0, 1'b0);
    applyStimulus(1'b1, i2, 1'b0, 1'b0);
    chk("stall_ready_low", 32'(if_ready), 32'd0);
    chk("stall_hold_first", 32'(imm_15bit), 32'h0123);
    applyStimulus(1'b1, i3, 1'b0, 1'b0);
    applyStimulus(1'b1, i3, 1'b1, 1'b0);
    chk("stall_second", 32'(alu_op), 32'b01001);
    applyStimulus(1'b1, i3, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    chk("stall_third", 32'(imm_15bit), 32'h5aa5);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Illegal opcode 111111, then bit 31 set on an otherwise valid ADDI.
    applyStimulus(1'b1, mk(6'b111111, 5'd1, 5'd1, 15'h1), 1'b1, 1'b0);
    chk("illegal_op", 32'({id_valid, illegal, mux4to1_select}), 32'b1100);
    applyStimulus(1'b1, 32'h80000000 | mk(6'b101000, 5'd2, 5'd2, 15'h2), 1'b1, 1'b0);
    chk("illegal_b31", 32'({id_valid, illegal, mux4to1_select}), 32'b1100);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush while full, with a fetch transfer offered in the same cycle.
    applyStimulus(1'b1, i1, 1'b0, 1'b0);
    applyStimulus(1'b1, i2, 1'b0, 1'b0);
    applyStimulus(1'b1, i3, 1'b1, 1'b1);
    chk("flush_valid", 32'(id_valid), 32'd0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Asynchronous reset while full, then a clean restart.
    applyStimulus(1'b1, i1, 1'b0, 1'b0);
    applyStimulus(1'b1, i2, 1'b0, 1'b0);
    if_valid = 1'b1; if_instr = i3;
    #1 rst = 1'b0;
    #1 checkZero("midreset");
    model_q.delete();
    @(negedge clk);
    rst = 1'b1;
    checkOutput();
    applyStimulus(1'b1, i3, 1'b1, 1'b0);
    chk("post_reset_first", 32'(imm_15bit), 32'h5aa5);

    // Random traffic.
    for (int n = 0; n < 400; n++)
      applyStimulus(($urandom_range(0, 3) != 0), randInstr(), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
    for (int n = 0; n < 3; n++)
      applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
